// File: rtl/fft_reorder_frame_if.sv
// rtl/fft_reorder_frame_if.sv - sample-in / result-out bundle for fft_reorder_frame; FFT_REORDER_BYPASS_EN adds i_natural
interface fft_reorder_frame_if #(
  parameter int DW    = 22,
  parameter int LGMAX = 11
);
  logic                         i_ce;
  logic                         i_sync;
  logic [2*DW-1:0]              i_sample;
  logic [$clog2(LGMAX+1)-1:0]   i_lgsize;
`ifdef FFT_REORDER_BYPASS_EN
  logic                         i_natural;
`endif
  logic                         o_valid;
  logic                         i_ready;
  logic [2*DW-1:0]              o_result;
  logic                         o_sync;
  logic                         o_overflow;

  modport master (
`ifdef FFT_REORDER_BYPASS_EN
    output i_natural,
`endif
    output i_ce, i_sync, i_sample, i_lgsize, i_ready,
    input  o_valid, o_result, o_sync, o_overflow
  );

  modport slave (
`ifdef FFT_REORDER_BYPASS_EN
    input  i_natural,
`endif
    input  i_ce, i_sync, i_sample, i_lgsize, i_ready,
    output o_valid, o_result, o_sync, o_overflow
  );
endinterface

// File: rtl/fft_reorder_frame.sv
// rtl/fft_reorder_frame.sv - ping-pong bit-reversal reorder with runtime length and overflow reporting
// FFT_REORDER_BYPASS_EN adds i_natural to pass natural-order frames straight through.
module fft_reorder_frame #(
  parameter int DW    = 22,
  parameter int LGMAX = 11,
  parameter int LGMIN = 3
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  fft_reorder_frame_if.slave bus
);
  localparam int LGW = $clog2(LGMAX + 1);
  localparam int AW  = LGMAX + 1;

  typedef enum logic { W_IDLE, W_FILL }  wr_state_t;
  typedef enum logic { R_IDLE, R_DRAIN } rd_state_t;

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;

  logic [2*DW-1:0]  mem [0:(1<<AW)-1];
  logic             bank_sel;
  logic [LGW-1:0]   wr_lg, rd_lg, lg_clamped, rd_shift;
  logic [LGMAX-1:0] wr_addr, wr_waddr, wr_last;
  logic [LGMAX-1:0] rd_cnt, rd_last, rd_rev, rd_addr;
  logic             wr_start, wr_en, wr_done;
  logic             rd_issue, rd_final, swap, drop;
`ifdef FFT_REORDER_BYPASS_EN
  logic             wr_nat, rd_nat;
`endif

  always_comb begin
    lg_clamped = bus.i_lgsize;
    if (bus.i_lgsize < LGW'(LGMIN))
      lg_clamped = LGW'(LGMIN);
    else if (bus.i_lgsize > LGW'(LGMAX))
      lg_clamped = LGW'(LGMAX);
  end

  assign wr_start = bus.i_ce && bus.i_sync;
  assign wr_en    = bus.i_ce && (bus.i_sync || w_state == W_FILL);
  assign wr_waddr = wr_start ? '0 : wr_addr;
  assign wr_last  = LGMAX'((32'd1 << wr_lg) - 32'd1);
  assign wr_done  = (w_state == W_FILL) && bus.i_ce && !bus.i_sync && (wr_addr == wr_last);

  assign rd_last  = LGMAX'((32'd1 << rd_lg) - 32'd1);
  assign rd_issue = (r_state == R_DRAIN) && (!bus.o_valid || bus.i_ready);
  assign rd_final = rd_issue && (rd_cnt == rd_last);
  // A reader finishing in the same cycle frees its bank for this completion.
  assign swap     = wr_done && ((r_state == R_IDLE) || rd_final);
  assign drop     = wr_done && !swap;

  always_comb begin
    rd_rev = '0;
    for (int i = 0; i < LGMAX; i++)
      rd_rev[i] = rd_cnt[LGMAX-1-i];
  end

  assign rd_shift = LGW'(LGMAX) - rd_lg;
`ifdef FFT_REORDER_BYPASS_EN
  assign rd_addr  = rd_nat ? rd_cnt : (rd_rev >> rd_shift);
`else
  assign rd_addr  = rd_rev >> rd_shift;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    r_next = r_state;
    if (wr_start)
      w_next = W_FILL;
    else if (wr_done)
      w_next = W_IDLE;
    if (swap)
      r_next = R_DRAIN;
    else if (rd_final)
      r_next = R_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[{bank_sel, wr_waddr}] <= bus.i_sample;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bank_sel       <= 1'b0;
      wr_lg          <= '0;
      rd_lg          <= '0;
      wr_addr        <= '0;
      rd_cnt         <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_sync     <= 1'b0;
      bus.o_overflow <= 1'b0;
      bus.o_result   <= '0;
`ifdef FFT_REORDER_BYPASS_EN
      wr_nat         <= 1'b0;
      rd_nat         <= 1'b0;
`endif
    end else begin
      bus.o_overflow <= drop;

      if (wr_start) begin
        wr_lg   <= lg_clamped;
        wr_addr <= LGMAX'(1);
`ifdef FFT_REORDER_BYPASS_EN
        wr_nat  <= bus.i_natural;
`endif
      end else if (wr_en) begin
        wr_addr <= wr_addr + LGMAX'(1);
      end

      // The output register doubles as the memory read register.
      if (rd_issue) begin
        bus.o_result <= mem[{~bank_sel, rd_addr}];
        bus.o_valid  <= 1'b1;
        bus.o_sync   <= (rd_cnt == '0);
        rd_cnt       <= rd_cnt + LGMAX'(1);
      end else if (bus.i_ready) begin
        bus.o_valid  <= 1'b0;
        bus.o_sync   <= 1'b0;
      end

      if (swap) begin
        bank_sel <= ~bank_sel;
        rd_lg    <= wr_lg;
        rd_cnt   <= '0;
`ifdef FFT_REORDER_BYPASS_EN
        rd_nat   <= wr_nat;
`endif
      end
    end
  end
endmodule

// File: tb/tb_fft_reorder_frame.sv
// tb/tb_fft_reorder_frame.sv - scoreboard bench for fft_reorder_frame; FFT_REORDER_BYPASS_EN enables the passthrough step
module tb_fft_reorder_frame;
  localparam int DW    = 22;
  localparam int LGMAX = 11;
  localparam int LGMIN = 3;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   ovf_cnt = 0;
  int   ovf_base;

  logic [2*DW:0] exp_q[$];
  logic [2*DW:0] held;
  logic [2*DW:0] exp_item;
  bit            was_stalled = 0;

  fft_reorder_frame_if #(.DW(DW), .LGMAX(LGMAX)) bus ();

  fft_reorder_frame #(.DW(DW), .LGMAX(LGMAX), .LGMIN(LGMIN)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int brev(input int v, input int lg);
    int r = 0;
    for (int i = 0; i < lg; i++)
      if (v[i]) r |= 1 << (lg - 1 - i);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      was_stalled = 0;
    end else begin
      if (bus.o_overflow) ovf_cnt++;
      if (was_stalled) begin
        check("hold_valid", 64'(bus.o_valid), 64'd1);
        check("hold_data", 64'({bus.o_sync, bus.o_result}), 64'(held));
      end
      was_stalled = 0;
      if (bus.o_valid) begin
        if (bus.i_ready) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_out: observed %0h expected none", bus.o_result);
          end
          if (exp_q.size() != 0) begin
            exp_item = exp_q.pop_front();
            check("out_word", 64'({bus.o_sync, bus.o_result}), 64'(exp_item));
          end
        end else begin
          was_stalled = 1;
          held = {bus.o_sync, bus.o_result};
        end
      end
    end
  end

  task automatic feed(input int lg_pin, input int lg, input int tag, input bit push, input bit nat);
    if (push)
      for (int k = 0; k < (1 << lg); k++)
        exp_q.push_back({(k == 0), DW'(tag), DW'(k)});
    for (int j = 0; j < (1 << lg); j++) begin
      @(posedge clk); #1;
      bus.i_ce     = 1'b1;
      bus.i_sync   = (j == 0);
      bus.i_lgsize = 4'(lg_pin);
`ifdef FFT_REORDER_BYPASS_EN
      bus.i_natural = nat;
`endif
      bus.i_sample = {DW'(tag), DW'(nat ? j : brev(j, lg))};
    end
    @(posedge clk); #1;
    bus.i_ce   = 1'b0;
    bus.i_sync = 1'b0;
  endtask

  task automatic wait_empty(input string tag, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.i_ce     = 1'b0;
    bus.i_sync   = 1'b0;
    bus.i_sample = '0;
    bus.i_lgsize = '0;
    bus.i_ready  = 1'b1;
`ifdef FFT_REORDER_BYPASS_EN
    bus.i_natural = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_sync", 64'(bus.o_sync), 64'd0);
    check("rst_ovf", 64'(bus.o_overflow), 64'd0);
    check("rst_result", 64'(bus.o_result), 64'd0);
    rst_n = 1'b1;

    // Lossless full-size frame and first-output latency
    ovf_base = ovf_cnt;
    feed(11, 11, 1, 1, 0);
    @(negedge clk);
    check("lat_n1_valid", 64'(bus.o_valid), 64'd0);
    @(negedge clk);
    check("lat_n2_valid", 64'(bus.o_valid), 64'd1);
    check("lat_n2_sync", 64'(bus.o_sync), 64'd1);
    wait_empty("drain_2048", 3000);

    // Runtime size change, back to back
    feed(3, 3, 2, 1, 0);
    feed(5, 5, 3, 1, 0);
    wait_empty("drain_3_5", 200);

    // Size clamping at both ends
    feed(2, 3, 4, 1, 0);
    wait_empty("clamp_low", 100);
    feed(12, 11, 5, 1, 0);
    wait_empty("clamp_high", 3000);
    check("ovf_none_a", 64'(ovf_cnt - ovf_base), 64'd0);

    // Back-pressure: second frame dropped, first drains intact
    ovf_base = ovf_cnt;
    bus.i_ready = 1'b0;
    feed(4, 4, 6, 1, 0);
    feed(4, 4, 7, 0, 0);
    @(negedge clk);
    check("ovf_pulse_hi", 64'(bus.o_overflow), 64'd1);
    @(negedge clk);
    check("ovf_pulse_lo", 64'(bus.o_overflow), 64'd0);
    check("stall_valid", 64'(bus.o_valid), 64'd1);
    @(posedge clk); #1;
    bus.i_ready = 1'b1;
    wait_empty("drain_after_drop", 100);
    check("ovf_once", 64'(ovf_cnt - ovf_base), 64'd1);

    // Alternating stall
    ovf_base = ovf_cnt;
    feed(4, 4, 8, 1, 0);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      bus.i_ready = ~bus.i_ready;
    end
    bus.i_ready = 1'b1;
    wait_empty("drain_alt_stall", 50);

    // Mid-frame resync discards the partial frame
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      bus.i_ce     = 1'b1;
      bus.i_sync   = (j == 0);
      bus.i_lgsize = 4'd4;
      bus.i_sample = {DW'(9), DW'(j)};
    end
    feed(4, 4, 10, 1, 0);
    wait_empty("drain_resync", 100);
    check("ovf_none_b", 64'(ovf_cnt - ovf_base), 64'd0);

    // Reset during drain
    feed(4, 4, 11, 1, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.o_valid), 64'd0);
    check("mid_rst_sync", 64'(bus.o_sync), 64'd0);
    check("mid_rst_ovf", 64'(bus.o_overflow), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    feed(4, 4, 12, 1, 0);
    wait_empty("drain_after_rst", 100);

`ifdef FFT_REORDER_BYPASS_EN
    feed(4, 4, 13, 1, 1);
    wait_empty("drain_bypass", 100);
    feed(4, 4, 14, 1, 0);
    wait_empty("drain_after_bypass", 100);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_reorder_frame.md
# fft_reorder_frame

Parametrised bit-reversal reorder stage for the pipelined FFT, with a runtime-selectable transform length. It sits between the last butterfly stage and the consumer. It accepts one complex sample per enabled clock, in bit-reversed order. It returns each frame in natural order through a valid/ready output with a per-frame sync, and reports frames it drops under back-pressure.

## Interface
Parameters:
- `DW`, 22 — width of each real or imaginary component; a sample is 2*DW bits, real part in the high half.
- `LGMAX`, 11 — log2 of the largest supported FFT length; the memory is 2 banks × 2^LGMAX words.
- `LGMIN`, 3 — log2 of the smallest supported length.

Ports:
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_ce`  in  1  input sample strobe; one sample is accepted per high cycle.
- `i_sync`  in  1  qualified by `i_ce`; marks the first sample of a frame.
- `i_sample`  in  2*DW  input sample, in bit-reversed order.
- `i_lgsize`  in  $clog2(LGMAX+1)  log2 of the frame length; sampled only on a synced write.
- `o_valid`  out  1  output sample valid.
- `i_ready`  in  1  consumer ready.
- `o_result`  out  2*DW  output sample, in natural order.
- `o_sync`  out  1  high with the first sample of each output frame.
- `o_overflow`  out  1  one-cycle pulse when a frame is dropped.

## Operation
- **Writer states: IDLE and FILL.**
  - IDLE: samples are ignored until `i_ce && i_sync`.
  - On that event:
    - latch `i_lgsize` into `wr_lg`, clamped to the range [LGMIN, LGMAX];
    - write the sample at address 0 of the write bank;
    - set `wr_addr` = 1 and enter FILL.
  - FILL: each `i_ce` writes the sample at `wr_addr` and increments it.
  - When `wr_addr` reaches 2^wr_lg − 1 and that sample is written, the frame is complete.
  - `i_sync` seen during FILL restarts the current bank at address 0 and re-latches the size. The partial frame is discarded silently, with no overflow pulse.
- **Frame completion.**
  - If the reader is IDLE: swap the banks, hand `wr_lg` to the reader, and return the writer to IDLE.
  - Otherwise: drop the frame, pulse `o_overflow`, and return the writer to IDLE. The bank is reused.
- **Reader states: IDLE and DRAIN.**
  - DRAIN walks `rd_cnt` from 0 to 2^rd_lg − 1.
  - Memory address = bit-reverse of the low `rd_lg` bits of `rd_cnt`.
  - The memory read has one cycle of latency. The output register is refilled when it is empty or `i_ready` is high.
  - `o_sync` is high with the word from `rd_cnt` = 0.
  - After the last word is issued, the reader returns to IDLE. Its bank becomes the write bank on the next swap.
- **Output hold.** While `o_valid && !i_ready`:
  - `o_result` and `o_sync` hold;
  - no new read is issued.
- **Simultaneous events.** The writer completing a frame in the same cycle the reader issues its last address counts as "reader IDLE": the swap occurs and nothing is dropped.
- **Reset.**
  - All outputs go to 0, both state machines to IDLE, bank select to 0, and all counters to 0.
  - Memory contents are undefined and never read before being written.
  - Reset asserted mid-frame discards all data in flight.

## Timing
- **Latency.** Last input sample accepted at cycle N, with the reader IDLE and `i_ready` high:
  - bank swap at N+1;
  - first read at N+1;
  - `o_valid` and `o_sync` at N+2.
  - Thereafter one word per cycle while `i_ready` is high.
- **Throughput.** Continuous input at one sample per clock is lossless only if the consumer keeps `i_ready` high.
- **Handshake.** `o_valid` never drops without a transfer (`o_valid && i_ready`). Output data is stable while stalled.
- **Overflow pulse.** `o_overflow` asserts in cycle N+1 relative to the dropped frame's last sample.

## Configuration
- **`FFT_REORDER_BYPASS_EN`** adds input `i_natural` (1 bit), latched alongside `i_lgsize`.
  - When the latched value is 1, the reader uses `rd_cnt` directly as the address, passing natural-order input through.
  - Without the macro the port does not exist and bit-reversal is always applied.

## Test plan
- **Lossless, LGMAX=11.** Size 11, continuous `i_ce`, sample = bitrev11(k) for k = 0..2047, `i_ready`=1 → `o_result` = 0,1,…,2047 starting at N+2. `o_sync` is high only on 0.
- **Runtime size change.** Size 3 frame then size 5 frame → outputs 0..7 then 0..31 in order, each with one `o_sync`. No overflow.
- **Back-pressure drop.** Hold `i_ready`=0 through two complete size-4 frames → the first frame drains afterwards intact and `o_overflow` pulses exactly once. Stall every other cycle → data is held and nothing is duplicated.
- **Mid-frame resync.** `i_sync` at sample 5 of a size-4 frame → only the restarted 16-sample frame appears. No overflow.
- **Reset mid-drain.** Pull `i_reset_n` low during DRAIN → `o_valid`, `o_sync` and `o_overflow` drop to 0 immediately. A new frame after release drains correctly.
- **Bypass.** With `FFT_REORDER_BYPASS_EN` and `i_natural`=1, feed 0..15 at size 4 → output is 0..15 unchanged.
